fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the program counter and issues one-at-a-time requests to instruction memory.
- Registers each returned instruction word with its PC and presents the pair to the decoder with a valid/stall handshake.
- Accepts redirects from the jump/branch resolution logic and discards any in-flight stale fetch.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response and decoder handoff.
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_opcode;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic        o_misaligned;

    modport master (
        output o_imem_req, o_imem_addr, o_opcode, o_pc, o_valid, o_misaligned,
        input  i_imem_ready, i_imem_valid, i_imem_rdata,
        input  i_stall, i_redirect, i_redirect_addr
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_opcode, o_pc, o_valid, o_misaligned,
        output i_imem_ready, i_imem_valid, i_imem_rdata,
        output i_stall, i_redirect, i_redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request,
// registered opcode/PC to the decoder with a one-deep hold buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_unit_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, HOLD, DRAIN, HALT
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] opcode_q, opcode_d;
    logic [31:0] opc_pc_q, opc_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_word_q, hold_word_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        mis_q, mis_d;
    logic        consume;

    assign consume          = valid_q & ~bus.i_stall;
    assign bus.o_imem_req   = (state_q == REQ);
    assign bus.o_imem_addr  = pc_q;
    assign bus.o_opcode     = opcode_q;
    assign bus.o_pc         = opc_pc_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_misaligned = mis_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            opcode_q    <= NOP;
            opc_pc_q    <= RESET_PC;
            valid_q     <= 1'b0;
            hold_word_q <= NOP;
            hold_pc_q   <= RESET_PC;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            opc_pc_q    <= opc_pc_d;
            valid_q     <= valid_d;
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
            mis_q       <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opcode_d    = opcode_q;
        opc_pc_d    = opc_pc_q;
        valid_d     = valid_q;
        hold_word_d = hold_word_q;
        hold_pc_d   = hold_pc_q;
        mis_d       = mis_q;

        if (state_q != HALT && bus.i_redirect) begin
            valid_d     = 1'b0;
            hold_word_d = NOP;
            if (bus.i_redirect_addr[1:0] != 2'b00) begin
                mis_d   = 1'b1;
                state_d = HALT;
            end else begin
                pc_d = bus.i_redirect_addr;
                // An accepted but unanswered request must be drained first
                unique case (state_q)
                    REQ:     state_d = bus.i_imem_ready ? DRAIN : REQ;
                    WAIT:    state_d = bus.i_imem_valid ? REQ : DRAIN;
                    DRAIN:   state_d = bus.i_imem_valid ? REQ : DRAIN;
                    default: state_d = REQ;
                endcase
            end
        end else begin
            if (consume) valid_d = 1'b0;
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (bus.i_imem_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (bus.i_imem_valid) begin
                        pc_d = pc_q + 32'd4;
                        if (!valid_q || consume) begin
                            opcode_d = bus.i_imem_rdata;
                            opc_pc_d = pc_q;
                            valid_d  = 1'b1;
                            state_d  = REQ;
                        end else begin
                            hold_word_d = bus.i_imem_rdata;
                            hold_pc_d   = pc_q;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        opcode_d = hold_word_q;
                        opc_pc_d = hold_pc_q;
                        valid_d  = 1'b1;
                        state_d  = REQ;
                    end
                end
                DRAIN: begin
                    if (bus.i_imem_valid) state_d = REQ;
                end
                HALT:    valid_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for fetch/stall, hand
// sequences for redirect, drain, misaligned halt and PC wrap.
module tb_fetch_unit;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus_a ();
    fetch_unit_if bus_b ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] op;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];

    function automatic vec_t mk(logic s, logic r, logic [31:0] a,
                                logic v, logic [31:0] p, logic [31:0] o);
        vec_t x;
        x.stall = s; x.req = r; x.addr = a;
        x.vld = v; x.pc = p; x.op = o;
        return x;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model A: ready driven by the test, response after `lat` cycles
    initial begin : mem_a
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        bus_a.i_imem_valid = 1'b0;
        bus_a.i_imem_rdata = '0;
        forever begin
            @(negedge clk);
            bus_a.i_imem_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus_a.i_imem_valid = 1'b1;
                        bus_a.i_imem_rdata = paddr ^ K;
                        pend = 1'b0;
                    end
                end
                if (bus_a.o_imem_req && bus_a.i_imem_ready) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = bus_a.o_imem_addr;
                end
            end
        end
    end

    // Memory model B: zero-wait, always ready
    initial begin : mem_b
        logic        pend;
        logic [31:0] paddr;
        pend = 1'b0; paddr = '0;
        bus_b.i_imem_ready    = 1'b1;
        bus_b.i_stall         = 1'b0;
        bus_b.i_redirect      = 1'b0;
        bus_b.i_redirect_addr = '0;
        bus_b.i_imem_valid    = 1'b0;
        bus_b.i_imem_rdata    = '0;
        forever begin
            @(negedge clk);
            bus_b.i_imem_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    bus_b.i_imem_valid = 1'b1;
                    bus_b.i_imem_rdata = paddr ^ K;
                    pend = 1'b0;
                end
                if (bus_b.o_imem_req) begin
                    pend  = 1'b1;
                    paddr = bus_b.o_imem_addr;
                end
            end
        end
    end

    task automatic reset_dut();
        #2;
        rst = 1'b1;
        bus_a.i_stall         = 1'b0;
        bus_a.i_redirect      = 1'b0;
        bus_a.i_redirect_addr = '0;
        bus_a.i_imem_ready    = 1'b1;
        lat = 1;
        #1;
        chk("rst_req",   32'(bus_a.o_imem_req),   32'd0);
        chk("rst_addr",  bus_a.o_imem_addr,       32'h100);
        chk("rst_op",    bus_a.o_opcode,          NOP);
        chk("rst_pc",    bus_a.o_pc,              32'h100);
        chk("rst_vld",   32'(bus_a.o_valid),      32'd0);
        chk("rst_mis",   32'(bus_a.o_misaligned), 32'd0);
        chk("rstb_addr", bus_b.o_imem_addr,       32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic run_table(string nm, input vec_t t[$]);
        foreach (t[i]) begin
            chk($sformatf("%s[%0d].req", nm, i),  32'(bus_a.o_imem_req), 32'(t[i].req));
            chk($sformatf("%s[%0d].addr", nm, i), bus_a.o_imem_addr,     t[i].addr);
            chk($sformatf("%s[%0d].vld", nm, i),  32'(bus_a.o_valid),    32'(t[i].vld));
            chk($sformatf("%s[%0d].pc", nm, i),   bus_a.o_pc,            t[i].pc);
            chk($sformatf("%s[%0d].op", nm, i),   bus_a.o_opcode,        t[i].op);
            bus_a.i_stall = t[i].stall;
            step();
        end
        bus_a.i_stall = 1'b0;
    endtask

    initial begin
        bus_a.i_stall         = 1'b0;
        bus_a.i_redirect      = 1'b0;
        bus_a.i_redirect_addr = '0;
        bus_a.i_imem_ready    = 1'b1;

        // Zero-wait sequential fetch, cycles 1..7 after reset release
        t1.push_back(mk(0, 1, 32'h100, 0, 32'h100, NOP));
        t1.push_back(mk(0, 0, 32'h100, 0, 32'h100, NOP));
        t1.push_back(mk(0, 1, 32'h104, 1, 32'h100, 32'h100 ^ K));
        t1.push_back(mk(0, 0, 32'h104, 0, 32'h100, 32'h100 ^ K));
        t1.push_back(mk(0, 1, 32'h108, 1, 32'h104, 32'h104 ^ K));
        t1.push_back(mk(0, 0, 32'h108, 0, 32'h104, 32'h104 ^ K));
        t1.push_back(mk(0, 1, 32'h10C, 1, 32'h108, 32'h108 ^ K));

        // Stall for 5 cycles from the first valid: 0x104 parks in HOLD
        t2.push_back(mk(0, 1, 32'h100, 0, 32'h100, NOP));
        t2.push_back(mk(0, 0, 32'h100, 0, 32'h100, NOP));
        t2.push_back(mk(1, 1, 32'h104, 1, 32'h100, 32'h100 ^ K));
        t2.push_back(mk(1, 0, 32'h104, 1, 32'h100, 32'h100 ^ K));
        t2.push_back(mk(1, 0, 32'h108, 1, 32'h100, 32'h100 ^ K));
        t2.push_back(mk(1, 0, 32'h108, 1, 32'h100, 32'h100 ^ K));
        t2.push_back(mk(1, 0, 32'h108, 1, 32'h100, 32'h100 ^ K));
        t2.push_back(mk(0, 0, 32'h108, 1, 32'h100, 32'h100 ^ K));
        t2.push_back(mk(0, 1, 32'h108, 1, 32'h104, 32'h104 ^ K));
        t2.push_back(mk(0, 0, 32'h108, 0, 32'h104, 32'h104 ^ K));
        t2.push_back(mk(0, 1, 32'h10C, 1, 32'h108, 32'h108 ^ K));

        reset_dut();
        run_table("seq", t1);
        reset_dut();
        run_table("stall", t2);

        // Redirect in WAIT; stale 0x108 response arrives three cycles later
        reset_dut();
        repeat (4) step();
        chk("wr_c5_addr", bus_a.o_imem_addr, 32'h108);
        lat = 4;
        step();
        chk("wr_c6_req", 32'(bus_a.o_imem_req), 32'd0);
        bus_a.i_redirect      = 1'b1;
        bus_a.i_redirect_addr = 32'h200;
        step();
        bus_a.i_redirect = 1'b0;
        lat = 1;
        for (int c = 7; c <= 9; c++) begin
            chk($sformatf("wr_c%0d_req", c), 32'(bus_a.o_imem_req), 32'd0);
            chk($sformatf("wr_c%0d_vld", c), 32'(bus_a.o_valid),    32'd0);
            chk($sformatf("wr_c%0d_op", c),  bus_a.o_opcode,        32'h104 ^ K);
            step();
        end
        chk("wr_c10_req",  32'(bus_a.o_imem_req), 32'd1);
        chk("wr_c10_addr", bus_a.o_imem_addr,     32'h200);
        chk("wr_c10_op",   bus_a.o_opcode,        32'h104 ^ K);
        repeat (2) step();
        chk("wr_c12_vld", 32'(bus_a.o_valid), 32'd1);
        chk("wr_c12_pc",  bus_a.o_pc,         32'h200);
        chk("wr_c12_op",  bus_a.o_opcode,     32'h200 ^ K);

        // Redirect together with a WAIT response: dropped, no drain
        step();
        chk("wv_c13_req", 32'(bus_a.o_imem_req), 32'd0);
        bus_a.i_redirect      = 1'b1;
        bus_a.i_redirect_addr = 32'h300;
        step();
        bus_a.i_redirect = 1'b0;
        chk("wv_c14_req",  32'(bus_a.o_imem_req), 32'd1);
        chk("wv_c14_addr", bus_a.o_imem_addr,     32'h300);
        chk("wv_c14_vld",  32'(bus_a.o_valid),    32'd0);
        chk("wv_c14_op",   bus_a.o_opcode,        32'h200 ^ K);
        repeat (2) step();
        chk("wv_c16_pc", bus_a.o_pc,     32'h300);
        chk("wv_c16_op", bus_a.o_opcode, 32'h300 ^ K);

        // Redirect together with REQ acceptance: must drain
        chk("rr_c16_req", 32'(bus_a.o_imem_req), 32'd1);
        bus_a.i_redirect      = 1'b1;
        bus_a.i_redirect_addr = 32'h400;
        step();
        bus_a.i_redirect = 1'b0;
        chk("rr_c17_req",  32'(bus_a.o_imem_req), 32'd0);
        chk("rr_c17_addr", bus_a.o_imem_addr,     32'h400);
        chk("rr_c17_vld",  32'(bus_a.o_valid),    32'd0);
        step();
        chk("rr_c18_req",  32'(bus_a.o_imem_req), 32'd1);
        chk("rr_c18_addr", bus_a.o_imem_addr,     32'h400);
        repeat (2) step();
        chk("rr_c20_vld", 32'(bus_a.o_valid), 32'd1);
        chk("rr_c20_pc",  bus_a.o_pc,         32'h400);
        chk("rr_c20_op",  bus_a.o_opcode,     32'h400 ^ K);

        // Misaligned redirect halts until reset
        bus_a.i_redirect      = 1'b1;
        bus_a.i_redirect_addr = 32'h302;
        step();
        bus_a.i_redirect = 1'b0;
        for (int c = 21; c <= 24; c++) begin
            chk($sformatf("ma_c%0d_mis", c), 32'(bus_a.o_misaligned), 32'd1);
            chk($sformatf("ma_c%0d_req", c), 32'(bus_a.o_imem_req),   32'd0);
            chk($sformatf("ma_c%0d_vld", c), 32'(bus_a.o_valid),      32'd0);
            bus_a.i_redirect      = (c == 22);
            bus_a.i_redirect_addr = 32'h500;
            step();
        end
        bus_a.i_redirect = 1'b0;
        reset_dut();
        chk("rs_c1_req",   32'(bus_a.o_imem_req), 32'd1);
        chk("rs_c1_addr",  bus_a.o_imem_addr,     32'h100);
        chk("wrap_c1_req", 32'(bus_b.o_imem_req), 32'd1);
        chk("wrap_c1_adr", bus_b.o_imem_addr,     32'hFFFF_FFFC);
        repeat (2) step();
        chk("rs_c3_vld",   32'(bus_a.o_valid),    32'd1);
        chk("rs_c3_op",    bus_a.o_opcode,        32'h100 ^ K);
        chk("wrap_c3_req", 32'(bus_b.o_imem_req), 32'd1);
        chk("wrap_c3_adr", bus_b.o_imem_addr,     32'h0000_0000);
        chk("wrap_c3_pc",  bus_b.o_pc,            32'hFFFF_FFFC);
        chk("wrap_c3_op",  bus_b.o_opcode,        32'hFFFF_FFFC ^ K);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
